approx_err_monitor: RTL and testbench

APPROX_ERR_MONITOR -- requirements
Module: approx_err_monitor

---
 rtl/approx_err_monitor_pkg.sv | 15 +
 rtl/approx_err_calc.sv | 24 ++
 rtl/approx_err_monitor.sv | 139 +++++++++++++
 tb/tb_approx_err_monitor.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_err_monitor_pkg.sv
// Shared types and defaults for the approximate-multiplier error monitor.
// Holds the run state encoding, default widths and the counter width.
package approx_err_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ACC_W = 32;
  localparam int CNT_W     = 16;

endpackage

// File: rtl/approx_err_calc.sv
// Error distance between the exact unsigned product and an approximate one.
// Purely combinational; the parent registers ed and nz.
module approx_err_calc
  import approx_err_monitor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] prod_approx,
  output logic [2*WIDTH-1:0] ed,
  output logic               nz
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] exact;

  assign exact = PW'(a) * PW'(b);
  assign nz    = (exact != prod_approx);
  assign ed    = (exact >= prod_approx) ? (exact - prod_approx)
                                        : (prod_approx - exact);

endmodule

// File: rtl/approx_err_monitor.sv
// Run controller and statistics for measuring approximate-multiplier error.
// Samples flow: input reg -> ED reg -> statistics (visible three cycles on).
module approx_err_monitor
  import approx_err_monitor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] prod_approx,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   err_count,
  output logic [ACC_W-1:0]   sum_ed,
  output logic [2*WIDTH-1:0] max_ed,
  output logic [CNT_W-1:0]   sample_count
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;

  state_t           state;
  logic [CNT_W-1:0] nsamp;
  logic [CNT_W-1:0] accepted;
  logic             fire;

  logic             s1_v;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [PW-1:0]    s1_p;

  logic             s2_v;
  logic [PW-1:0]    s2_ed;
  logic             s2_nz;

  logic [PW-1:0]    ed;
  logic             nz;
  logic [SW-1:0]    sum_nxt;
  logic             sum_sat;

  assign busy     = (state == RUN);
  assign in_ready = (state == RUN) && (accepted < nsamp);
  assign fire     = in_valid && in_ready;

  approx_err_calc #(
    .WIDTH(WIDTH)
  ) u_calc (
    .a          (s1_a),
    .b          (s1_b),
    .prod_approx(s1_p),
    .ed         (ed),
    .nz         (nz)
  );

  // Widen before adding so the carry-out flags saturation.
  assign sum_nxt = SW'(sum_ed) + SW'(s2_ed);
  assign sum_sat = |sum_nxt[SW-1:ACC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      nsamp        <= '0;
      accepted     <= '0;
      done         <= 1'b0;
      s1_v         <= 1'b0;
      s1_a         <= '0;
      s1_b         <= '0;
      s1_p         <= '0;
      s2_v         <= 1'b0;
      s2_ed        <= '0;
      s2_nz        <= 1'b0;
      err_count    <= '0;
      sum_ed       <= '0;
      max_ed       <= '0;
      sample_count <= '0;
    end else begin
      done <= 1'b0;

      s1_v <= fire;
      if (fire) begin
        s1_a <= a;
        s1_b <= b;
        s1_p <= prod_approx;
      end

      s2_v <= s1_v;
      if (s1_v) begin
        s2_ed <= ed;
        s2_nz <= nz;
      end

      if (s2_v) begin
        if (sample_count != '1)
          sample_count <= sample_count + 1'b1;
        if (s2_nz && (err_count != '1))
          err_count <= err_count + 1'b1;
        sum_ed <= sum_sat ? '1 : sum_nxt[ACC_W-1:0];
        if (s2_ed > max_ed)
          max_ed <= s2_ed;
      end

      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            nsamp        <= num_samples;
            accepted     <= '0;
            err_count    <= '0;
            sum_ed       <= '0;
            max_ed       <= '0;
            sample_count <= '0;
            if (num_samples == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (fire)
            accepted <= accepted + 1'b1;
          if ((accepted == nsamp) && !s1_v && !s2_v) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed bench for approx_err_monitor, default widths plus ACC_W=16.
// Both instances share stimulus; the narrow one checks sum saturation.
module tb_approx_err_monitor;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] prod_approx;

  logic        in_ready;
  logic        busy;
  logic        done;
  logic [15:0] err_count;
  logic [31:0] sum_ed;
  logic [15:0] max_ed;
  logic [15:0] sample_count;

  logic        in_ready_16;
  logic        busy_16;
  logic        done_16;
  logic [15:0] err_count_16;
  logic [15:0] sum_ed_16;
  logic [15:0] max_ed_16;
  logic [15:0] sample_count_16;

  int cmp;
  int errs;
  int accepts;
  int done_cnt;

  approx_err_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .prod_approx (prod_approx),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .sum_ed      (sum_ed),
    .max_ed      (max_ed),
    .sample_count(sample_count)
  );

  approx_err_monitor #(
    .WIDTH(8),
    .ACC_W(16)
  ) dut16 (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready_16),
    .a           (a),
    .b           (b),
    .prod_approx (prod_approx),
    .busy        (busy_16),
    .done        (done_16),
    .err_count   (err_count_16),
    .sum_ed      (sum_ed_16),
    .max_ed      (max_ed_16),
    .sample_count(sample_count_16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    start       = 1'b1;
    num_samples = n;
    step();
    start       = 1'b0;
  endtask

  task automatic send(input logic [7:0] va, input logic [7:0] vb,
                      input logic [15:0] vp);
    logic ok;
    ok          = 1'b0;
    in_valid    = 1'b1;
    a           = va;
    b           = vb;
    prod_approx = vp;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) chk("send_timeout", 64'(ok), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    cmp         = 0;
    errs        = 0;
    rst         = 1'b1;
    start       = 1'b0;
    num_samples = '0;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    prod_approx = '0;

    step();
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    chk("rst_sum", 64'(sum_ed), 64'd0);
    chk("rst_max", 64'(max_ed), 64'd0);
    chk("rst_cnt", 64'(sample_count), 64'd0);
    rst = 1'b0;
    step();

    // One exact sample, with retirement latency checked
    do_start(16'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_ready", 64'(in_ready), 64'd1);
    send(8'd15, 8'd15, 16'd225);
    chk("t1_lat1", 64'(sample_count), 64'd0);
    step();
    chk("t1_lat2", 64'(sample_count), 64'd0);
    step();
    chk("t1_lat3", 64'(sample_count), 64'd1);
    wait_done("t1_done");
    chk("t1_cnt", 64'(sample_count), 64'd1);
    chk("t1_err", 64'(err_count), 64'd0);
    chk("t1_sum", 64'(sum_ed), 64'd0);
    chk("t1_max", 64'(max_ed), 64'd0);
    chk("t1_busy_done", 64'(busy), 64'd0);
    step();
    chk("t1_done_pulse", 64'(done), 64'd0);

    // Two erroneous samples: ED 5 and 65025
    do_start(16'd2);
    send(8'd15, 8'd15, 16'd220);
    send(8'd255, 8'd255, 16'd0);
    wait_done("t2_done");
    chk("t2_cnt", 64'(sample_count), 64'd2);
    chk("t2_err", 64'(err_count), 64'd2);
    chk("t2_sum", 64'(sum_ed), 64'd65030);
    chk("t2_max", 64'(max_ed), 64'd65025);
    chk("t2_sum16", 64'(sum_ed_16), 64'd65030);

    // Zero-length run
    do_start(16'd0);
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_ready", 64'(in_ready), 64'd0);
    chk("t3_busy", 64'(busy), 64'd0);
    chk("t3_cnt", 64'(sample_count), 64'd0);
    chk("t3_sum", 64'(sum_ed), 64'd0);
    chk("t3_max", 64'(max_ed), 64'd0);
    chk("t3_err", 64'(err_count), 64'd0);
    step();
    chk("t3_done_pulse", 64'(done), 64'd0);
    chk("t3_ready2", 64'(in_ready), 64'd0);

    // Toggling in_valid, ED 9 each; a start in RUN must be ignored
    do_start(16'd3);
    accepts     = 0;
    done_cnt    = 0;
    a           = 8'd7;
    b           = 8'd7;
    prod_approx = 16'd40;
    for (int i = 0; i < 16; i++) begin
      in_valid = (i % 2 == 0);
      if (i == 1) begin
        start       = 1'b1;
        num_samples = 16'd9;
      end else begin
        start = 1'b0;
      end
      if (in_valid && in_ready) accepts++;
      step();
      if (done) done_cnt++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("t4_accepts", 64'(accepts), 64'd3);
    chk("t4_ready", 64'(in_ready), 64'd0);
    chk("t4_done_cnt", 64'(done_cnt), 64'd1);
    chk("t4_cnt", 64'(sample_count), 64'd3);
    chk("t4_err", 64'(err_count), 64'd3);
    chk("t4_sum", 64'(sum_ed), 64'd27);
    chk("t4_max", 64'(max_ed), 64'd9);

    // Reset mid-run after two retired samples
    do_start(16'd4);
    send(8'd2, 8'd2, 16'd5);
    send(8'd2, 8'd2, 16'd5);
    step();
    step();
    chk("t5_pre_cnt", 64'(sample_count), 64'd2);
    rst = 1'b1;
    step();
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_ready", 64'(in_ready), 64'd0);
    chk("t5_cnt", 64'(sample_count), 64'd0);
    chk("t5_sum", 64'(sum_ed), 64'd0);
    chk("t5_max", 64'(max_ed), 64'd0);
    chk("t5_err", 64'(err_count), 64'd0);
    rst      = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) done_cnt++;
    end
    chk("t5_no_done", 64'(done_cnt), 64'd0);
    chk("t5_idle", 64'(busy), 64'd0);
    do_start(16'd1);
    send(8'd3, 8'd4, 16'd12);
    wait_done("t5_done");
    chk("t5_new_cnt", 64'(sample_count), 64'd1);
    chk("t5_new_err", 64'(err_count), 64'd0);

    // Accumulator saturation on the 16-bit instance
    do_start(16'd2);
    send(8'd255, 8'd255, 16'd0);
    send(8'd255, 8'd255, 16'd0);
    wait_done("t6_done");
    chk("t6_sum16", 64'(sum_ed_16), 64'hFFFF);
    chk("t6_max16", 64'(max_ed_16), 64'd65025);
    chk("t6_sum32", 64'(sum_ed), 64'd130050);
    chk("t6_cnt16", 64'(sample_count_16), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
